vram_sdram_writer: RTL and testbench

- Read side of the GPMC-to-VRAM write queue: drains the 32-bit async FIFO in the SDRAM clock domain and turns each entry into two single-byte SDRAM writes on the 8-bit VRAM bus.
- Owns SDRAM power-up initialisation and periodic auto-refresh.
- Write-only. Display read-out arbitration is a later block.

---
 rtl/vram_sdram_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_vram_sdram_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_sdram_writer.sv
// ---------------------------------------------------------------------------
// vram_sdram_writer : drains the GPMC write FIFO into byte-wide SDRAM writes,
//                     and owns SDRAM power-up init and periodic auto-refresh.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vram_sdram_writer #(
  parameter int          INIT_WAIT        = 20000,
  parameter int          T_RCD            = 2,
  parameter int          T_WR             = 2,
  parameter int          T_RP             = 2,
  parameter int          T_RFC            = 7,
  parameter int          REFRESH_INTERVAL = 750,
  parameter logic [12:0] MODE_WORD        = 13'h020
) (
  input  logic        vram_clk,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_read_data,
  output logic        fifo_read,
  output logic [12:0] vram_addr,
  output logic [1:0]  vram_bank,
  output logic [7:0]  vram_data_out,
  output logic        vram_data_oe,
  output logic        vram_cke,
  output logic        vram_cs,
  output logic        vram_ras,
  output logic        vram_cas,
  output logic        vram_we,
  output logic        vram_dqm,
  output logic        init_done,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_INIT_WAIT = 3'd0,
    S_INIT_PRE  = 3'd1,
    S_INIT_REF  = 3'd2,
    S_INIT_MODE = 3'd3,
    S_IDLE      = 3'd4,
    S_REF       = 3'd5,
    S_WRITE     = 3'd6
  } state_t;

  localparam logic [3:0] C_CMD_DESEL = 4'b1111;
  localparam logic [3:0] C_CMD_NOP   = 4'b0111;
  localparam logic [3:0] C_CMD_ACT   = 4'b0011;
  localparam logic [3:0] C_CMD_WRITE = 4'b0100;
  localparam logic [3:0] C_CMD_PRE   = 4'b0010;
  localparam logic [3:0] C_CMD_REF   = 4'b0001;
  localparam logic [3:0] C_CMD_MRS   = 4'b0000;

  localparam int C_SEQ_LAST = T_RCD + 1 + T_WR + T_RP;
  localparam int C_CNT_W    = $clog2(INIT_WAIT + C_SEQ_LAST + T_RFC + T_RP + 4);
  localparam int C_REF_W    = $clog2(REFRESH_INTERVAL + 1);

  state_t               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic                 second_ref_q, second_ref_d;
  logic [31:0]          entry_q, entry_d;
  logic [C_REF_W-1:0]   ref_ctr_q, ref_ctr_d;
  logic                 ref_pend_q, ref_pend_d;
  logic [3:0]           cmd_q, cmd_d;
  logic [12:0]          addr_q, addr_d;
  logic [1:0]           bank_q, bank_d;
  logic [7:0]           data_q, data_d;
  logic                 oe_q, oe_d;
  logic                 cke_q, cke_d;
  logic                 fifo_read_q, fifo_read_d;
  logic                 init_done_q, init_done_d;
  logic                 busy_q, busy_d;
  logic                 dispatch;

  // Next state is resolved first; outputs are then decoded from the next
  // state so every pin is registered yet aligned with the state it belongs to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 1'b1;
    second_ref_d = second_ref_q;
    entry_d      = entry_q;
    ref_ctr_d    = ref_ctr_q;
    ref_pend_d   = ref_pend_q;
    init_done_d  = init_done_q;
    fifo_read_d  = 1'b0;
    dispatch     = 1'b0;

    if (init_done_q) begin
      if (ref_ctr_q == C_REF_W'(REFRESH_INTERVAL - 1)) begin
        ref_ctr_d  = '0;
        ref_pend_d = 1'b1;
      end else begin
        ref_ctr_d = ref_ctr_q + 1'b1;
      end
    end

    case (state_q)
      S_INIT_WAIT: if (cnt_q == C_CNT_W'(INIT_WAIT)) begin
        state_d = S_INIT_PRE;
        cnt_d   = '0;
      end
      S_INIT_PRE: if (cnt_q == C_CNT_W'(T_RP)) begin
        state_d      = S_INIT_REF;
        cnt_d        = '0;
        second_ref_d = 1'b0;
      end
      S_INIT_REF: if (cnt_q == C_CNT_W'(T_RFC)) begin
        cnt_d = '0;
        if (second_ref_q) state_d = S_INIT_MODE;
        else second_ref_d = 1'b1;
      end
      S_INIT_MODE: if (cnt_q == C_CNT_W'(2)) begin
        state_d     = S_IDLE;
        cnt_d       = '0;
        init_done_d = 1'b1;
      end
      S_IDLE:  dispatch = 1'b1;
      S_REF:   dispatch = (cnt_q == C_CNT_W'(T_RFC));
      S_WRITE: dispatch = (cnt_q == C_CNT_W'(C_SEQ_LAST));
      default: state_d = S_INIT_WAIT;
    endcase

    // The last cycle of a sequence doubles as an idle decision, so the next
    // command can land straight after the trailing NOPs.
    if (dispatch) begin
      cnt_d = '0;
      if (ref_pend_q) begin
        state_d    = S_REF;
        ref_pend_d = 1'b0;
      end else if (!fifo_empty) begin
        state_d     = S_WRITE;
        entry_d     = fifo_read_data;
        fifo_read_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    cmd_d  = C_CMD_NOP;
    addr_d = addr_q;
    bank_d = bank_q;
    data_d = data_q;
    oe_d   = 1'b0;
    cke_d  = 1'b1;
    case (state_d)
      S_INIT_PRE: if (cnt_d == '0) begin
        cmd_d  = C_CMD_PRE;
        addr_d = 13'h0400;
      end
      S_INIT_REF, S_REF: if (cnt_d == '0) cmd_d = C_CMD_REF;
      S_INIT_MODE: if (cnt_d == '0) begin
        cmd_d  = C_CMD_MRS;
        addr_d = MODE_WORD;
        bank_d = 2'b00;
      end
      S_WRITE: begin
        if (cnt_d == '0) begin
          cmd_d  = C_CMD_ACT;
          bank_d = entry_d[31:30];
          addr_d = {4'b0, entry_d[29:21]};
        end else if (cnt_d == C_CNT_W'(T_RCD)) begin
          cmd_d  = C_CMD_WRITE;
          addr_d = {7'b0, entry_d[20:16], 1'b0};
          data_d = entry_d[7:0];
          oe_d   = 1'b1;
        end else if (cnt_d == C_CNT_W'(T_RCD + 1)) begin
          cmd_d  = C_CMD_WRITE;
          addr_d = {2'b0, 1'b1, 4'b0, entry_d[20:16], 1'b1};
          data_d = entry_d[15:8];
          oe_d   = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge vram_clk) begin
    if (reset) begin
      state_q      <= S_INIT_WAIT;
      cnt_q        <= '0;
      second_ref_q <= 1'b0;
      entry_q      <= '0;
      ref_ctr_q    <= '0;
      ref_pend_q   <= 1'b0;
      cmd_q        <= C_CMD_DESEL;
      addr_q       <= '0;
      bank_q       <= '0;
      data_q       <= '0;
      oe_q         <= 1'b0;
      cke_q        <= 1'b0;
      fifo_read_q  <= 1'b0;
      init_done_q  <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      second_ref_q <= second_ref_d;
      entry_q      <= entry_d;
      ref_ctr_q    <= ref_ctr_d;
      ref_pend_q   <= ref_pend_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      bank_q       <= bank_d;
      data_q       <= data_d;
      oe_q         <= oe_d;
      cke_q        <= cke_d;
      fifo_read_q  <= fifo_read_d;
      init_done_q  <= init_done_d;
      busy_q       <= busy_d;
    end
  end

  assign {vram_cs, vram_ras, vram_cas, vram_we} = cmd_q;
  assign vram_addr     = addr_q;
  assign vram_bank     = bank_q;
  assign vram_data_out = data_q;
  assign vram_data_oe  = oe_q;
  assign vram_cke      = cke_q;
  assign vram_dqm      = 1'b0;
  assign fifo_read     = fifo_read_q;
  assign init_done     = init_done_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_vram_sdram_writer.sv
// ---------------------------------------------------------------------------
// tb_vram_sdram_writer : directed self-checking bench for vram_sdram_writer.
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_vram_sdram_writer;

  localparam int RI = 60;
  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_MRS = 4'b0000;

  logic        vram_clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [31:0] fifo_read_data = 32'h0;
  logic        fifo_read, vram_data_oe, vram_cke, vram_dqm, init_done, busy;
  logic        vram_cs, vram_ras, vram_cas, vram_we;
  logic [12:0] vram_addr;
  logic [1:0]  vram_bank;
  logic [7:0]  vram_data_out;
  logic [3:0]  w_cmd;

  int n_cmp = 0;
  int n_fail = 0;
  int hi_cnt = 0;
  int ref_seen = 0;
  int pop_cnt = 0;
  logic [31:0] fifo_q[$];

  assign w_cmd = {vram_cs, vram_ras, vram_cas, vram_we};

  always #5 vram_clk = ~vram_clk;

  vram_sdram_writer #(.INIT_WAIT(10), .REFRESH_INTERVAL(RI)) dut (
    .vram_clk(vram_clk), .reset(reset), .fifo_empty(fifo_empty),
    .fifo_read_data(fifo_read_data), .fifo_read(fifo_read),
    .vram_addr(vram_addr), .vram_bank(vram_bank), .vram_data_out(vram_data_out),
    .vram_data_oe(vram_data_oe), .vram_cke(vram_cke), .vram_cs(vram_cs),
    .vram_ras(vram_ras), .vram_cas(vram_cas), .vram_we(vram_we),
    .vram_dqm(vram_dqm), .init_done(init_done), .busy(busy)
  );

  // Advance one cycle, sample 1 ns after the edge, and keep the FIFO model current.
  task automatic tick();
    @(posedge vram_clk);
    #1;
    if (reset) begin
      hi_cnt = 0;
      ref_seen = 0;
    end else if (init_done) begin
      hi_cnt++;
      if (w_cmd == C_REF) ref_seen++;
    end
    if (fifo_read) begin
      pop_cnt++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_read_data = (fifo_q.size() > 0) ? fifo_q[0] : 32'h0;
  endtask

  task automatic push(input logic [31:0] e);
    fifo_q.push_back(e);
    fifo_empty = 1'b0;
    fifo_read_data = fifo_q[0];
  endtask

  task automatic wait_phase(input int p);
    bit hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick();
      if (init_done && (hi_cnt % RI) == p) hit = 1;
    end
    n_cmp++;
    if (!hit) begin n_fail++; $display("FAIL wait_phase: phase %0d not reached, got 0 expected 1", p); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_cmp++; if (w_cmd !== 4'b1111) begin n_fail++; $display("FAIL rst_cmd: got %b expected 1111", w_cmd); end
    n_cmp++; if (vram_cke !== 1'b0) begin n_fail++; $display("FAIL rst_cke: got %b expected 0", vram_cke); end
    n_cmp++; if (vram_data_oe !== 1'b0) begin n_fail++; $display("FAIL rst_oe: got %b expected 0", vram_data_oe); end
    n_cmp++; if (fifo_read !== 1'b0) begin n_fail++; $display("FAIL rst_pop: got %b expected 0", fifo_read); end
    n_cmp++; if ({vram_addr, vram_bank, vram_data_out} !== 23'h0) begin n_fail++; $display("FAIL rst_addr: got %h expected 0", {vram_addr, vram_bank, vram_data_out}); end
    n_cmp++; if ({init_done, busy, vram_dqm} !== 3'b010) begin n_fail++; $display("FAIL rst_flags: got %b expected 010", {init_done, busy, vram_dqm}); end
  endtask

  task automatic test_init();
    logic [3:0] exp_cmd;
    reset = 1'b0;
    for (int c = 1; c <= 33; c++) begin
      tick();
      exp_cmd = C_NOP;
      if (c == 11) exp_cmd = C_PRE;
      if (c == 14 || c == 22) exp_cmd = C_REF;
      if (c == 30) exp_cmd = C_MRS;
      n_cmp++;
      if (w_cmd !== exp_cmd) begin n_fail++; $display("FAIL init_cmd c%0d: got %b expected %b", c, w_cmd, exp_cmd); end
      if (c == 1) begin
        n_cmp++; if (vram_cke !== 1'b1) begin n_fail++; $display("FAIL init_cke: got %b expected 1", vram_cke); end
      end
      if (c == 11) begin
        n_cmp++; if (vram_addr[10] !== 1'b1) begin n_fail++; $display("FAIL init_pre_a10: got %b expected 1", vram_addr[10]); end
      end
      if (c == 30) begin
        n_cmp++; if ({vram_bank, vram_addr} !== {2'b00, 13'h020}) begin n_fail++; $display("FAIL init_mode_addr: got %h expected 0020", {vram_bank, vram_addr}); end
      end
      if (c == 30 || c == 33) begin
        n_cmp++;
        if (init_done !== (c == 33)) begin n_fail++; $display("FAIL init_done c%0d: got %b expected %b", c, init_done, (c == 33)); end
      end
    end
  endtask

  task automatic test_single_write();
    bit found = 0;
    int oe_cycles = 0;
    int pops0;
    wait_phase(10);
    pops0 = pop_cnt;
    push({16'hC123, 16'hBEEF});
    for (int i = 0; i < 5 && !found; i++) begin
      tick();
      if (fifo_read) found = 1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL sw_pop: got 0 expected 1"); end
    n_cmp++; if ({w_cmd, vram_bank, vram_addr} !== {C_ACT, 2'd3, 13'd9}) begin n_fail++; $display("FAIL sw_act: got %h expected %h", {w_cmd, vram_bank, vram_addr}, {C_ACT, 2'd3, 13'd9}); end
    oe_cycles += int'(vram_data_oe);
    tick();
    n_cmp++; if ({w_cmd, vram_data_oe, busy} !== {C_NOP, 2'b01}) begin n_fail++; $display("FAIL sw_trcd: got %b expected %b", {w_cmd, vram_data_oe, busy}, {C_NOP, 2'b01}); end
    oe_cycles += int'(vram_data_oe);
    tick();
    n_cmp++; if ({w_cmd, vram_bank, vram_addr, vram_data_out, vram_data_oe} !== {C_WR, 2'd3, 13'h006, 8'hEF, 1'b1}) begin n_fail++; $display("FAIL sw_wr_lo: got %h expected %h", {w_cmd, vram_bank, vram_addr, vram_data_out, vram_data_oe}, {C_WR, 2'd3, 13'h006, 8'hEF, 1'b1}); end
    oe_cycles += int'(vram_data_oe);
    tick();
    n_cmp++; if ({w_cmd, vram_bank, vram_addr, vram_data_out, vram_data_oe} !== {C_WR, 2'd3, 13'h407, 8'hBE, 1'b1}) begin n_fail++; $display("FAIL sw_wr_hi: got %h expected %h", {w_cmd, vram_bank, vram_addr, vram_data_out, vram_data_oe}, {C_WR, 2'd3, 13'h407, 8'hBE, 1'b1}); end
    oe_cycles += int'(vram_data_oe);
    repeat (5) begin
      tick();
      oe_cycles += int'(vram_data_oe);
    end
    n_cmp++; if (oe_cycles != 2) begin n_fail++; $display("FAIL sw_oe_cycles: got %0d expected 2", oe_cycles); end
    n_cmp++; if (pop_cnt - pops0 != 1) begin n_fail++; $display("FAIL sw_pop_count: got %0d expected 1", pop_cnt - pops0); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ent [3];
    logic [14:0] exp_act [3];
    logic [20:0] exp_wlo [3];
    int act_cyc [3];
    int n_act = 0;
    int n_wlo = 0;
    int late_cmds = 0;
    int pops0;
    ent[0] = {16'h0000, 16'h1234}; exp_act[0] = {2'd0, 13'h000}; exp_wlo[0] = {13'h000, 8'h34};
    ent[1] = {16'h7FFF, 16'hA55A}; exp_act[1] = {2'd1, 13'h1FF}; exp_wlo[1] = {13'h03E, 8'h5A};
    ent[2] = {16'h8021, 16'h00FF}; exp_act[2] = {2'd2, 13'h001}; exp_wlo[2] = {13'h002, 8'hFF};
    wait_phase(10);
    pops0 = pop_cnt;
    for (int k = 0; k < 3; k++) push(ent[k]);
    for (int c = 0; c < 40; c++) begin
      tick();
      if (w_cmd == C_ACT && n_act < 3) begin
        act_cyc[n_act] = c;
        n_cmp++;
        if ({vram_bank, vram_addr} !== exp_act[n_act]) begin n_fail++; $display("FAIL b2b_act%0d: got %h expected %h", n_act, {vram_bank, vram_addr}, exp_act[n_act]); end
        n_act++;
      end
      if (w_cmd == C_WR && vram_addr[10] == 1'b0 && n_wlo < 3) begin
        n_cmp++;
        if ({vram_addr, vram_data_out} !== exp_wlo[n_wlo]) begin n_fail++; $display("FAIL b2b_wlo%0d: got %h expected %h", n_wlo, {vram_addr, vram_data_out}, exp_wlo[n_wlo]); end
        n_wlo++;
      end
      if (n_act == 3 && c > act_cyc[2] + 3 && w_cmd != C_NOP) late_cmds++;
    end
    n_cmp++; if (n_act != 3) begin n_fail++; $display("FAIL b2b_act_count: got %0d expected 3", n_act); end
    if (n_act == 3) begin
      n_cmp++; if (act_cyc[1] - act_cyc[0] != 8) begin n_fail++; $display("FAIL b2b_gap01: got %0d expected 8", act_cyc[1] - act_cyc[0]); end
      n_cmp++; if (act_cyc[2] - act_cyc[1] != 8) begin n_fail++; $display("FAIL b2b_gap12: got %0d expected 8", act_cyc[2] - act_cyc[1]); end
    end
    n_cmp++; if (pop_cnt - pops0 != 3) begin n_fail++; $display("FAIL b2b_pops: got %0d expected 3", pop_cnt - pops0); end
    n_cmp++; if (late_cmds != 0) begin n_fail++; $display("FAIL b2b_idle_nop: got %0d expected 0", late_cmds); end
  endtask

  task automatic test_refresh_contention();
    logic [3:0] exp_cmd;
    wait_phase(RI - 1);
    push({16'h4000, 16'h1111});
    push({16'h4001, 16'h2222});
    tick();
    n_cmp++; if (fifo_read !== 1'b1) begin n_fail++; $display("FAIL rc_pop: got %b expected 1", fifo_read); end
    for (int c = 0; c <= 16; c++) begin
      if (c > 0) tick();
      exp_cmd = C_NOP;
      if (c == 0 || c == 16) exp_cmd = C_ACT;
      if (c == 2 || c == 3) exp_cmd = C_WR;
      if (c == 8) exp_cmd = C_REF;
      n_cmp++;
      if (w_cmd !== exp_cmd) begin n_fail++; $display("FAIL rc_cmd N+%0d: got %b expected %b", c, w_cmd, exp_cmd); end
    end
    repeat (10) tick();
  endtask

  task automatic test_refresh_count();
    for (int r = 0; r < 2; r++) begin
      wait_phase(30);
      n_cmp++;
      if (ref_seen != hi_cnt / RI) begin n_fail++; $display("FAIL ref_count%0d: got %0d expected %0d", r, ref_seen, hi_cnt / RI); end
    end
  endtask

  task automatic test_reset_mid_write();
    bit found = 0;
    int pops0;
    int writes = 0;
    int refs = 0;
    int mrs = 0;
    wait_phase(10);
    push({16'h0042, 16'h9876});
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (w_cmd == C_WR && vram_addr[10] == 1'b0) found = 1;
    end
    n_cmp++; if (!found) begin n_fail++; $display("FAIL rmw_wr_lo: got 0 expected 1"); end
    reset = 1'b1;
    pops0 = pop_cnt;
    tick();
    n_cmp++; if ({vram_cs, vram_cke, vram_data_oe, init_done} !== 4'b1000) begin n_fail++; $display("FAIL rmw_reset_pins: got %b expected 1000", {vram_cs, vram_cke, vram_data_oe, init_done}); end
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (w_cmd == C_WR) writes++;
      if (w_cmd == C_REF) refs++;
      if (w_cmd == C_MRS) mrs++;
    end
    n_cmp++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL rmw_reinit_done: got %b expected 1", init_done); end
    n_cmp++; if ({refs, mrs} != {32'd2, 32'd1}) begin n_fail++; $display("FAIL rmw_reinit_seq: got ref %0d mode %0d expected ref 2 mode 1", refs, mrs); end
    n_cmp++; if (writes != 0) begin n_fail++; $display("FAIL rmw_rewrite: got %0d expected 0", writes); end
    n_cmp++; if (pop_cnt != pops0) begin n_fail++; $display("FAIL rmw_extra_pop: got %0d expected %0d", pop_cnt, pops0); end
  endtask

  task automatic test_no_pop_init();
    int early = 0;
    bit done = 0;
    bit popped = 0;
    push({16'h0100, 16'h5A5A});
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      tick();
      if (fifo_read && !init_done) early++;
      if (init_done) done = 1;
    end
    n_cmp++; if (!done) begin n_fail++; $display("FAIL npi_init_done: got 0 expected 1"); end
    n_cmp++; if (early != 0) begin n_fail++; $display("FAIL npi_early_pop: got %0d expected 0", early); end
    for (int c = 0; c < 3 && !popped; c++) begin
      tick();
      if (fifo_read) popped = 1;
    end
    n_cmp++; if (!popped) begin n_fail++; $display("FAIL npi_pop_after_init: got 0 expected 1"); end
    repeat (10) tick();
    n_cmp++; if (fifo_q.size() != 0) begin n_fail++; $display("FAIL npi_fifo_drained: got %0d expected 0", fifo_q.size()); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_single_write();
    test_back_to_back();
    test_refresh_contention();
    test_refresh_count();
    test_reset_mid_write();
    test_no_pop_init();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
